complete_arbiter: RTL and testbench

Shares the single completion/writeback broadcast (CompleteNotif: regfile write port plus rename-table pending clear) among the execute pipes. Each pipe presents at most one finished instruction per cycle. The block grants one pipe per cycle in round-robin order and registers the winner onto the broadcast. Completions younger than an in-flight squash are consumed without being broadcast.

---
 rtl/complete_arbiter_if.sv | 41 ++++
 rtl/complete_arbiter.sv | 100 ++++++++++
 tb/tb_complete_arbiter.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/complete_arbiter_if.sv
// Completion broadcast bundle: per-pipe finished-instruction requests, the squash
// broadcast, and the registered CompleteNotif payload.
interface complete_arbiter_if #(
    parameter int p_num_pipes      = 2,
    parameter int p_seq_num_bits   = 5,
    parameter int p_phys_addr_bits = 6
);
    logic [p_num_pipes-1:0]                       req_val;
    logic [p_num_pipes-1:0]                       req_rdy;
    logic [p_num_pipes-1:0][p_seq_num_bits-1:0]   req_seq_num;
    logic [p_num_pipes-1:0][4:0]                  req_waddr;
    logic [p_num_pipes-1:0][p_phys_addr_bits-1:0] req_preg;
    logic [p_num_pipes-1:0][31:0]                 req_wdata;
    logic [p_num_pipes-1:0]                       req_wen;

    logic                                         squash_val;
    logic [p_seq_num_bits-1:0]                    squash_seq_num;

    logic                                         complete_val;
    logic [p_seq_num_bits-1:0]                    complete_seq_num;
    logic [4:0]                                   complete_waddr;
    logic [p_phys_addr_bits-1:0]                  complete_preg;
    logic [31:0]                                  complete_wdata;
    logic                                         complete_wen;

    modport master (
        output req_val, req_seq_num, req_waddr, req_preg, req_wdata, req_wen,
        output squash_val, squash_seq_num,
        input  req_rdy,
        input  complete_val, complete_seq_num, complete_waddr, complete_preg,
        input  complete_wdata, complete_wen
    );

    modport slave (
        input  req_val, req_seq_num, req_waddr, req_preg, req_wdata, req_wen,
        input  squash_val, squash_seq_num,
        output req_rdy,
        output complete_val, complete_seq_num, complete_waddr, complete_preg,
        output complete_wdata, complete_wen
    );
endinterface

// File: rtl/complete_arbiter.sv
// Round-robin arbiter sharing the single completion broadcast among execute pipes;
// squashed completions are consumed silently, and a late squash masks the registered entry.
module complete_arbiter #(
    parameter int p_num_pipes      = 2,
    parameter int p_seq_num_bits   = 5,
    parameter int p_phys_addr_bits = 6
) (
    input logic               clk,
    input logic               rst,
    complete_arbiter_if.slave bus
);
    localparam int PTR_W = (p_num_pipes > 1) ? $clog2(p_num_pipes) : 1;

    // Younger than the squasher: modular distance in [1, 2^(W-1)-1].
    function automatic logic is_younger(input logic [p_seq_num_bits-1:0] s,
                                        input logic [p_seq_num_bits-1:0] sq);
        logic [p_seq_num_bits-1:0] d;
        d = s - sq;
        return (d != '0) && !d[p_seq_num_bits-1];
    endfunction

    logic [PTR_W-1:0]            ptr;
    logic [p_num_pipes-1:0]      killed;
    logic [p_num_pipes-1:0]      live;
    logic [p_num_pipes-1:0]      rdy_c;
    logic                        grant_found;
    logic [PTR_W-1:0]            grant_idx;
    logic [PTR_W-1:0]            scan_idx;
    logic [PTR_W-1:0]            ptr_nxt;

    logic                        vld_p1;
    logic [p_seq_num_bits-1:0]   seq_p1;
    logic [4:0]                  waddr_p1;
    logic [p_phys_addr_bits-1:0] preg_p1;
    logic [31:0]                 wdata_p1;
    logic                        wen_p1;

    // Stage p0: kill filter and grant selection, purely combinational on this cycle's inputs.
    always_comb begin
        killed = '0;
        for (int i = 0; i < p_num_pipes; i++) begin
            killed[i] = bus.req_val[i] & bus.squash_val &
                        is_younger(bus.req_seq_num[i], bus.squash_seq_num);
        end
        live = bus.req_val & ~killed;

        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int i = 0; i < p_num_pipes; i++) begin
            scan_idx = PTR_W'((int'(ptr) + i) % p_num_pipes);
            if (!grant_found && live[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
        if (rst) begin
            grant_found = 1'b0;
        end

        rdy_c = '0;
        if (!rst) begin
            rdy_c = killed;
            if (grant_found) begin
                rdy_c[grant_idx] = 1'b1;
            end
        end

        ptr_nxt = (grant_idx == PTR_W'(p_num_pipes - 1)) ? '0 : grant_idx + 1'b1;
    end

    assign bus.req_rdy = rdy_c;

    // Stage p1: broadcast register; payload only loads on a grant and is never reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr    <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= grant_found;
            if (grant_found) begin
                ptr <= ptr_nxt;
            end
        end
        if (grant_found) begin
            seq_p1   <= bus.req_seq_num[grant_idx];
            waddr_p1 <= bus.req_waddr[grant_idx];
            preg_p1  <= bus.req_preg[grant_idx];
            wdata_p1 <= bus.req_wdata[grant_idx];
            wen_p1   <= bus.req_wen[grant_idx];
        end
    end

    assign bus.complete_val     = vld_p1 & ~(bus.squash_val & is_younger(seq_p1, bus.squash_seq_num));
    assign bus.complete_seq_num = seq_p1;
    assign bus.complete_waddr   = waddr_p1;
    assign bus.complete_preg    = preg_p1;
    assign bus.complete_wdata   = wdata_p1;
    assign bus.complete_wen     = wen_p1;
endmodule

// File: tb/tb_complete_arbiter.sv
// Scoreboard bench for complete_arbiter: a reference model predicts req_rdy each cycle
// and queues the broadcast expected one cycle later.
module tb_complete_arbiter;
    localparam int N = 3;
    localparam int S = 5;
    localparam int P = 6;

    typedef struct {
        bit           val;
        logic [S-1:0] seq;
        logic [4:0]   waddr;
        logic [P-1:0] preg;
        logic [31:0]  wdata;
        logic         wen;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    complete_arbiter_if #(.p_num_pipes(N), .p_seq_num_bits(S), .p_phys_addr_bits(P)) bus ();
    complete_arbiter #(.p_num_pipes(N), .p_seq_num_bits(S), .p_phys_addr_bits(P)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t         q[$];
    int           n_vec = 0;
    int           n_err = 0;
    int           mptr  = 0;
    logic [N-1:0] obs_rdy;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic bit younger(input logic [S-1:0] s, input logic [S-1:0] sq);
        int d;
        d = (int'(s) - int'(sq) + (1 << S)) % (1 << S);
        return (d >= 1) && (d <= (1 << (S - 1)) - 1);
    endfunction

    task automatic set_req(input int i, input logic [S-1:0] s, input logic [P-1:0] p,
                           input logic [31:0] d);
        bus.req_val[i]     = 1'b1;
        bus.req_seq_num[i] = s;
        bus.req_preg[i]    = p;
        bus.req_waddr[i]   = p[4:0] ^ 5'h15;
        bus.req_wdata[i]   = d;
        bus.req_wen[i]     = ~p[1];
    endtask

    // One clock: model predicts rdy, checks last cycle's broadcast, queues this cycle's.
    task automatic step();
        exp_t         e;
        exp_t         o;
        logic [N-1:0] kill;
        logic [N-1:0] er;
        int           g;
        @(negedge clk);
        kill = '0;
        er = '0;
        g = -1;
        e.val = 0; e.seq = '0; e.waddr = '0; e.preg = '0; e.wdata = '0; e.wen = 1'b0;
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                kill[i] = bus.req_val[i] && bus.squash_val &&
                          younger(bus.req_seq_num[i], bus.squash_seq_num);
            end
            for (int k = 0; k < N; k++) begin
                int j;
                j = (mptr + k) % N;
                if (g < 0 && bus.req_val[j] && !kill[j]) g = j;
            end
            er = kill;
            if (g >= 0) begin
                er[g]   = 1'b1;
                e.val   = 1;
                e.seq   = bus.req_seq_num[g];
                e.waddr = bus.req_waddr[g];
                e.preg  = bus.req_preg[g];
                e.wdata = bus.req_wdata[g];
                e.wen   = bus.req_wen[g];
            end
        end
        obs_rdy = bus.req_rdy;
        check("req_rdy", obs_rdy, er);
        if (q.size() > 0) begin
            o = q.pop_front();
            check("complete_val", bus.complete_val,
                  o.val && !(bus.squash_val && younger(o.seq, bus.squash_seq_num)));
            if (o.val) begin
                check("complete_seq", bus.complete_seq_num, o.seq);
                check("complete_waddr", bus.complete_waddr, o.waddr);
                check("complete_preg", bus.complete_preg, o.preg);
                check("complete_wdata", bus.complete_wdata, o.wdata);
                check("complete_wen", bus.complete_wen, o.wen);
            end
        end
        q.push_back(e);
        if (rst) mptr = 0;
        else if (g >= 0) mptr = (g + 1) % N;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.req_val = '0; bus.req_seq_num = '0; bus.req_waddr = '0;
        bus.req_preg = '0; bus.req_wdata = '0; bus.req_wen = '0;
        bus.squash_val = 1'b0; bus.squash_seq_num = '0;
        set_req(0, 5'd1, 6'd1, 32'h1111);
        step();
        step();
        check("reset_rdy", obs_rdy, 3'b000);
        rst = 1'b0;
        bus.req_val = '0;
        step();

        // Single request: rdy same cycle, one broadcast cycle after.
        set_req(0, 5'd3, 6'd40, 32'hDEADBEEF);
        step();
        check("single_rdy", obs_rdy, 3'b001);
        bus.req_val = '0;
        step();
        step();

        // Two contending pipes alternate with no bubbles.
        reset_pulse();
        set_req(0, 5'd10, 6'd10, 32'hA000_0000);
        set_req(1, 5'd11, 6'd11, 32'hB000_0000);
        for (int k = 0; k < 6; k++) begin
            step();
            check("alternate", obs_rdy, (k % 2) ? 3'b010 : 3'b001);
            for (int i = 0; i < 2; i++) begin
                if (obs_rdy[i]) set_req(i, 5'(12 + k), 6'(20 + k + i), 32'hC000_0000 + 32'(k));
            end
        end
        bus.req_val = '0;
        step();

        // Pointer wrap from the last pipe back to pipe 0.
        reset_pulse();
        set_req(2, 5'd7, 6'd50, 32'h2222_0000);
        step();
        check("wrap_g2", obs_rdy, 3'b100);
        set_req(2, 5'd8, 6'd51, 32'h2222_0001);
        set_req(0, 5'd9, 6'd52, 32'h0000_0009);
        step();
        check("wrap_g0", obs_rdy, 3'b001);
        bus.req_val[0] = 1'b0;
        step();
        check("wrap_g2b", obs_rdy, 3'b100);
        bus.req_val = '0;
        step();

        // Younger request killed at the arbiter, older one survives.
        bus.squash_val = 1'b1; bus.squash_seq_num = 5'd4;
        set_req(0, 5'd6, 6'd33, 32'h6666);
        set_req(1, 5'd2, 6'd34, 32'h2222);
        step();
        check("kill_rdy", obs_rdy, 3'b011);
        bus.squash_val = 1'b0;
        bus.req_val = '0;
        step();

        // Age comparison across the sequence-number wrap.
        bus.squash_val = 1'b1; bus.squash_seq_num = 5'd30;
        set_req(0, 5'd1, 6'd3, 32'h0101);
        step();
        bus.squash_seq_num = 5'd1;
        set_req(0, 5'd30, 6'd4, 32'h3030);
        step();
        bus.squash_val = 1'b0;
        bus.req_val = '0;
        step();

        // Squash arriving while the entry sits in the output register.
        set_req(0, 5'd9, 6'd9, 32'h9999);
        step();
        bus.req_val = '0;
        bus.squash_val = 1'b1; bus.squash_seq_num = 5'd7;
        step();
        bus.squash_val = 1'b0;
        step();

        // Reset with a registered entry clears it and returns ptr to pipe 0.
        set_req(1, 5'd12, 6'd12, 32'h1212);
        step();
        bus.req_val = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        set_req(1, 5'd13, 6'd13, 32'h1313);
        set_req(2, 5'd14, 6'd14, 32'h1414);
        step();
        check("rst_ptr", obs_rdy, 3'b010);
        bus.req_val[1] = 1'b0;
        step();
        bus.req_val = '0;
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
